// File: rtl/ldst_cpl_queue.sv
// ldst_cpl_queue: in-order completion buffer between the load/store FU and the
// CDB/ROB complete port. It absorbs CDB back-pressure, squashes wrong-path
// entries on branch recovery and clears resolved branch bits.
// Optional feature macro: LDST_CPL_BYPASS_EN. When it is defined and the queue
// is empty, an incoming completion drives cpl_* in the same cycle.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_*_i           FU completion (valid, wr_prf, data, tag, rob index, br mask)
//   rob_br_*_i       branch recovery / correct-prediction events
//   cpl_gnt_i        grant for the head entry
//   full_o           queue full; the FU must stall
//   cpl_*_o          head entry request and fields
module ldst_cpl_queue #(
  parameter int DEPTH     = 4,
  parameter int XLEN      = 64,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_TAG_W = 6,
  parameter int BR_MASK_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld_i,
  input  logic                 in_wr_prf_i,
  input  logic [XLEN-1:0]      in_data_i,
  input  logic [PRF_IDX_W-1:0] in_tag_i,
  input  logic [ROB_TAG_W-1:0] in_rob_idx_i,
  input  logic [BR_MASK_W-1:0] in_br_mask_i,
  input  logic                 rob_br_recovery_i,
  input  logic                 rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0] rob_br_tag_fix_i,
  input  logic                 cpl_gnt_i,
  output logic                 full_o,
  output logic                 cpl_vld_o,
  output logic                 cpl_wr_prf_o,
  output logic [XLEN-1:0]      cpl_data_o,
  output logic [PRF_IDX_W-1:0] cpl_tag_o,
  output logic [ROB_TAG_W-1:0] cpl_rob_idx_o,
  output logic [BR_MASK_W-1:0] cpl_br_mask_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]     vld_q;
  logic [DEPTH-1:0]     wr_q;
  logic [XLEN-1:0]      data_q [DEPTH];
  logic [PRF_IDX_W-1:0] tag_q  [DEPTH];
  logic [ROB_TAG_W-1:0] rob_q  [DEPTH];
  logic [BR_MASK_W-1:0] mask_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                 empty;
  logic                 head_vld;
  logic                 q_req;
  logic                 byp_take;
  logic                 push;
  logic                 pop;
  logic [BR_MASK_W-1:0] fix_clr;
  logic [BR_MASK_W-1:0] in_mask_fixed;

  assign empty         = (count_q == '0);
  assign full_o        = (count_q == CW'(DEPTH));
  assign fix_clr       = rob_br_pred_correct_i ? rob_br_tag_fix_i : '0;
  assign in_mask_fixed = in_br_mask_i & ~fix_clr;
  assign head_vld      = vld_q[head_q] & ~empty;
  assign q_req         = head_vld & ~rob_br_recovery_i;

`ifdef LDST_CPL_BYPASS_EN
  logic byp;
  assign byp      = empty & in_vld_i & ~rob_br_recovery_i;
  // A granted bypass is consumed directly and never stored.
  assign byp_take = byp & cpl_gnt_i;

  always_comb begin
    cpl_vld_o     = q_req;
    cpl_wr_prf_o  = wr_q[head_q];
    cpl_data_o    = data_q[head_q];
    cpl_tag_o     = tag_q[head_q];
    cpl_rob_idx_o = rob_q[head_q];
    cpl_br_mask_o = mask_q[head_q];
    if (byp) begin
      cpl_vld_o     = 1'b1;
      cpl_wr_prf_o  = in_wr_prf_i;
      cpl_data_o    = in_data_i;
      cpl_tag_o     = in_tag_i;
      cpl_rob_idx_o = in_rob_idx_i;
      cpl_br_mask_o = in_mask_fixed;
    end
  end
`else
  assign byp_take      = 1'b0;
  assign cpl_vld_o     = q_req;
  assign cpl_wr_prf_o  = wr_q[head_q];
  assign cpl_data_o    = data_q[head_q];
  assign cpl_tag_o     = tag_q[head_q];
  assign cpl_rob_idx_o = rob_q[head_q];
  assign cpl_br_mask_o = mask_q[head_q];
`endif

  // A squashed head (bubble) pops without a request; a live head needs a grant.
  // Recovery freezes pointers so bubbles drain afterwards.
  assign pop  = ~rob_br_recovery_i & ~empty
              & (~vld_q[head_q] | cpl_gnt_i);
  assign push = in_vld_i & ~full_o & ~rob_br_recovery_i & ~byp_take;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        rob_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rob_br_recovery_i && |(mask_q[i] & rob_br_tag_fix_i))
          vld_q[i] <= 1'b0;
        mask_q[i] <= mask_q[i] & ~fix_clr;
      end
      if (pop)
        vld_q[head_q] <= 1'b0;
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        wr_q[tail_q]   <= in_wr_prf_i;
        data_q[tail_q] <= in_data_i;
        tag_q[tail_q]  <= in_tag_i;
        rob_q[tail_q]  <= in_rob_idx_i;
        mask_q[tail_q] <= in_mask_fixed;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Presenting a completion while full is an FU protocol error; it is dropped.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(in_vld_i && full_o)
  ) else $warning("ldst_cpl_queue: in_vld_i while full, input dropped");

endmodule
